// File: rtl/mem_router.sv
// Routes a single memory request to the CLINT or the system bus and returns one response.
// Optional bus timeout when MEM_ROUTER_TIMEOUT_EN is defined.
module mem_router #(
  parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] CLINT_MASK = 64'hFFFF_FFFF_FFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_router_valid_i,
  input  logic [63:0] mem_router_addr_i,
  input  logic [63:0] mem_router_data_write_i,
  input  logic [1:0]  mem_router_size_i,
  input  logic        mem_router_req_i,
  output logic        mem_router_ready_o,
  output logic [63:0] mem_router_data_read_o,
  output logic [1:0]  mem_router_resp_o,
  output logic        mem_router_clint_valid_o,
  output logic [63:0] mem_router_clint_addr_o,
  output logic [63:0] mem_router_clint_data_write_o,
  output logic [1:0]  mem_router_clint_size_o,
  output logic        mem_router_clint_req_o,
  input  logic        mem_router_clint_ready_i,
  input  logic [63:0] mem_router_clint_data_read_i,
  input  logic [1:0]  mem_router_clint_resp_i,
  output logic        mem_router_bus_valid_o,
  output logic [63:0] mem_router_bus_addr_o,
  output logic [63:0] mem_router_bus_data_write_o,
  output logic [1:0]  mem_router_bus_size_o,
  output logic        mem_router_bus_req_o,
  input  logic        mem_router_bus_ready_i,
  input  logic [63:0] mem_router_bus_data_read_i,
  input  logic [1:0]  mem_router_bus_resp_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLINT = 2'd1;
  localparam logic [1:0] BUS   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        req_reg;
  logic [63:0] rdata_reg;
  logic [1:0]  resp_reg;
  logic        misaligned;
  logic        is_clint;

`ifdef MEM_ROUTER_TIMEOUT_EN
  logic [7:0]  tcount_reg;
`endif

  // Alignment is judged on the live request since it is decided in the latching cycle.
  always_comb begin
    misaligned = 1'b0;
    case (mem_router_size_i)
      2'd1:    misaligned = mem_router_addr_i[0];
      2'd2:    misaligned = |mem_router_addr_i[1:0];
      2'd3:    misaligned = |mem_router_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign is_clint = (mem_router_addr_i & CLINT_MASK) == CLINT_BASE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      size_reg   <= '0;
      req_reg    <= 1'b0;
      rdata_reg  <= '0;
      resp_reg   <= '0;
`ifdef MEM_ROUTER_TIMEOUT_EN
      tcount_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_router_valid_i) begin
            addr_reg  <= mem_router_addr_i;
            wdata_reg <= mem_router_data_write_i;
            size_reg  <= mem_router_size_i;
            req_reg   <= mem_router_req_i;
            if (misaligned) begin
              rdata_reg <= '0;
              resp_reg  <= 2'b10;
              state_reg <= DONE;
            end else if (is_clint) begin
              state_reg <= CLINT;
            end else begin
              state_reg  <= BUS;
`ifdef MEM_ROUTER_TIMEOUT_EN
              tcount_reg <= '0;
`endif
            end
          end
        end
        CLINT: begin
          if (mem_router_clint_ready_i) begin
            rdata_reg <= mem_router_clint_data_read_i;
            resp_reg  <= mem_router_clint_resp_i;
            state_reg <= DONE;
          end
        end
        BUS: begin
          if (mem_router_bus_ready_i) begin
            rdata_reg <= mem_router_bus_data_read_i;
            resp_reg  <= mem_router_bus_resp_i;
            state_reg <= DONE;
          end
`ifdef MEM_ROUTER_TIMEOUT_EN
          // A late ready still wins over the timeout in the same cycle.
          else if (tcount_reg == 8'hFF) begin
            rdata_reg <= '0;
            resp_reg  <= 2'b11;
            state_reg <= DONE;
          end else begin
            tcount_reg <= tcount_reg + 8'd1;
          end
`endif
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_router_ready_o     = (state_reg == DONE);
  assign mem_router_data_read_o = rdata_reg;
  assign mem_router_resp_o      = resp_reg;

  assign mem_router_clint_valid_o      = (state_reg == CLINT);
  assign mem_router_clint_addr_o       = addr_reg;
  assign mem_router_clint_data_write_o = wdata_reg;
  assign mem_router_clint_size_o       = size_reg;
  assign mem_router_clint_req_o        = req_reg;

  assign mem_router_bus_valid_o      = (state_reg == BUS);
  assign mem_router_bus_addr_o       = addr_reg;
  assign mem_router_bus_data_write_o = wdata_reg;
  assign mem_router_bus_size_o       = size_reg;
  assign mem_router_bus_req_o        = req_reg;

endmodule

// File: tb/tb_mem_router.sv
// Scoreboard bench for mem_router: stimulus pushes expected responses, a monitor checks each ready_o pulse.
module tb_mem_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  size_i;
  logic        req_i;
  logic        ready_o;
  logic [63:0] rdata_o;
  logic [1:0]  resp_o;
  logic        clint_valid;
  logic [63:0] clint_addr;
  logic [63:0] clint_wdata;
  logic [1:0]  clint_size;
  logic        clint_req;
  logic        clint_ready;
  logic [63:0] clint_rdata;
  logic [1:0]  clint_resp;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [1:0]  bus_size;
  logic        bus_req;
  logic        bus_ready;
  logic [63:0] bus_rdata;
  logic [1:0]  bus_resp;

  mem_router dut (
    .clk                           (clk),
    .rst                           (rst),
    .mem_router_valid_i            (valid_i),
    .mem_router_addr_i             (addr_i),
    .mem_router_data_write_i       (wdata_i),
    .mem_router_size_i             (size_i),
    .mem_router_req_i              (req_i),
    .mem_router_ready_o            (ready_o),
    .mem_router_data_read_o        (rdata_o),
    .mem_router_resp_o             (resp_o),
    .mem_router_clint_valid_o      (clint_valid),
    .mem_router_clint_addr_o       (clint_addr),
    .mem_router_clint_data_write_o (clint_wdata),
    .mem_router_clint_size_o       (clint_size),
    .mem_router_clint_req_o        (clint_req),
    .mem_router_clint_ready_i      (clint_ready),
    .mem_router_clint_data_read_i  (clint_rdata),
    .mem_router_clint_resp_i       (clint_resp),
    .mem_router_bus_valid_o        (bus_valid),
    .mem_router_bus_addr_o         (bus_addr),
    .mem_router_bus_data_write_o   (bus_wdata),
    .mem_router_bus_size_o         (bus_size),
    .mem_router_bus_req_o          (bus_req),
    .mem_router_bus_ready_i        (bus_ready),
    .mem_router_bus_data_read_i    (bus_rdata),
    .mem_router_bus_resp_i         (bus_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ready_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ready_o pulse; also guards downstream exclusivity.
  always @(negedge clk) begin
    check("valid_exclusive", {63'd0, clint_valid & bus_valid}, 64'd0);
    if (ready_o) begin
      ready_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("resp cycle=%0d data=%h resp=%0d", cyc, rdata_o, resp_o);
        check("rsp_data", rdata_o, mon_e.data);
        check("rsp_resp", {62'd0, resp_o}, {62'd0, mon_e.resp});
        check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Drives one request now (just after an edge, DUT idle); lat<0 means no response is expected.
  task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                       input logic r, input logic [63:0] ed, input logic [1:0] er,
                       input int lat, output int c);
    exp_t e;
    c = cyc;
    valid_i = 1'b1;
    addr_i  = a;
    wdata_i = d;
    size_i  = s;
    req_i   = r;
    if (lat >= 0) begin
      e.data = ed;
      e.resp = er;
      e.cyc  = c + lat;
      sb.push_back(e);
    end
    $display("req cycle=%0d addr=%h size=%0d req=%0d", c, a, s, r);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    int c;
    int seen0;
    rst = 1'b1; valid_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = '0; req_i = 1'b0;
    clint_ready = 1'b0; clint_rdata = '0; clint_resp = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_resp", {62'd0, resp_o}, 64'd0);
    check("rst_valids", {62'd0, clint_valid, bus_valid}, 64'd0);
    check("rst_addr", bus_addr | clint_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // CLINT read, ready immediately
    clint_ready = 1'b1; clint_rdata = 64'h1234; clint_resp = 2'b00;
    issue(64'h0200_BFF8, 64'h0, 2'd3, 1'b0, 64'h1234, 2'b00, 2, c);
    @(negedge clk);
    check("clint_valid_on", {63'd0, clint_valid}, 64'd1);
    check("clint_addr", clint_addr, 64'h0200_BFF8);
    check("clint_size", {62'd0, clint_size}, 64'd3);
    @(posedge clk); #1;
    clint_ready = 1'b0; clint_rdata = 64'hFFFF;
    @(negedge clk);
    check("clint_valid_off", {63'd0, clint_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rdata_hold", rdata_o, 64'h1234);
    @(posedge clk); #1;

    // Bus write, ready after 5 waiting cycles; mem-side inputs scrambled meanwhile
    bus_rdata = 64'h1111; bus_resp = 2'b00;
    issue(64'h8000_0010, 64'hDEAD_BEEF, 2'd2, 1'b1, 64'h1111, 2'b00, 7, c);
    addr_i = 64'h0200_0000; wdata_i = 64'h5; size_i = 2'd0; req_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bus_valid_held", {63'd0, bus_valid}, 64'd1);
      check("bus_addr", bus_addr, 64'h8000_0010);
      check("bus_wdata", bus_wdata, 64'hDEAD_BEEF);
      check("bus_size_req", {61'd0, bus_size, bus_req}, {61'd0, 2'd2, 1'b1});
      check("bus_no_clint", {63'd0, clint_valid}, 64'd0);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(posedge clk); #1;

    // Misaligned word read
    issue(64'h8000_0002, 64'h0, 2'd2, 1'b0, 64'h0, 2'b10, 1, c);
    @(negedge clk);
    check("misalign_no_valid", {62'd0, clint_valid, bus_valid}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset during the second bus cycle aborts silently
    issue(64'h8000_0020, 64'h0, 2'd3, 1'b0, 64'h0, 2'b00, -1, c);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_bus_valid", {63'd0, bus_valid}, 64'd0);
    check("abort_ready", {63'd0, ready_o}, 64'd0);
    check("abort_rdata", rdata_o, 64'd0);
    check("abort_resp", {62'd0, resp_o}, 64'd0);
    check("abort_addr", bus_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: CLINT write then bus read issued the cycle after ready_o
    clint_ready = 1'b1; clint_rdata = 64'h55; clint_resp = 2'b00;
    issue(64'h0200_4000, 64'hA5A5_0000_1234_5678, 2'd3, 1'b1, 64'h55, 2'b00, 2, c);
    @(negedge clk);
    check("b2b_clint_addr", clint_addr, 64'h0200_4000);
    check("b2b_clint_wdata", clint_wdata, 64'hA5A5_0000_1234_5678);
    check("b2b_clint_req", {63'd0, clint_req}, 64'd1);
    @(posedge clk); #1;
    clint_ready = 1'b0;
    @(posedge clk); #1;
    bus_ready = 1'b1; bus_rdata = 64'hCAFE; bus_resp = 2'b01;
    issue(64'h8000_0100, 64'h0, 2'd3, 1'b0, 64'hCAFE, 2'b01, 2, c);
    @(negedge clk);
    check("b2b_bus_valid", {63'd0, bus_valid}, 64'd1);
    check("b2b_bus_addr", bus_addr, 64'h8000_0100);
    check("b2b_bus_req", {63'd0, bus_req}, 64'd0);
    @(posedge clk); #1;
    bus_ready = 1'b0; bus_rdata = 64'h9999; bus_resp = 2'b00;
    @(posedge clk); #1;

    // Bus never answers
`ifdef MEM_ROUTER_TIMEOUT_EN
    issue(64'h8000_0200, 64'h0, 2'd3, 1'b0, 64'h0, 2'b11, 257, c);
    repeat (262) @(posedge clk);
    #1;
`else
    seen0 = ready_seen;
    issue(64'h8000_0200, 64'h0, 2'd3, 1'b0, 64'h0, 2'b00, -1, c);
    repeat (1000) @(posedge clk);
    #1;
    check("no_timeout_ready", 64'(ready_seen - seen0), 64'd0);
    @(negedge clk);
    check("no_timeout_valid", {63'd0, bus_valid}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
